// File: rtl/dom_shared_mul_gf2n_multi.sv
// rtl/dom_shared_mul_gf2n_multi.sv - pipelined DOM-indep shared GF(2^N) multiplier, NCH channels sharing one Y
//
// Purpose:
//   Q_c = X_c * Y over GF(2^N) on SHARES-way Boolean-masked operands.
//   Every cross-domain term X[i]*Y[j] is masked with fresh Z before it is
//   registered. Share outputs only XOR registered terms.
//
// Parameters:
//   N          field width (reduction polynomial picked in gf2_mul)
//   SHARES     number of shares (>=2); NPAIR = SHARES*(SHARES-1)/2
//   NCH        number of X channels multiplied by the common Y
//   PIPELINED  1: input register stage, latency 2; 0: latency 1
//
// Ports:
//   ClkxCI       clock, rising edge
//   RstxBI       asynchronous active-low reset
//   InValidxSI   X/Y valid this cycle (Z one cycle later when PIPELINED=1)
//   _XxDI        [(c*SHARES+i)*N +: N] = channel c, share i
//   _YxDI        [i*N +: N] = share i of Y
//   _ZxDI        [(c*NPAIR+p)*N +: N], p enumerates pairs i<j lexicographically
//   _QxDO        packed like _XxDI
//   OutValidxSO  _QxDO holds a fresh result
//
// Configuration:
//   DOM_MUL_CLEAR_ON_IDLE_EN  when defined, idle stage registers load zero
//                             instead of holding, so _QxDO reads 0 when idle.

module gf2_mul #(
  parameter int N = 4
) (
  input  logic [N-1:0] AxDI,
  input  logic [N-1:0] BxDI,
  output logic [N-1:0] QxDO
);
  // Low-order bits of the irreducible reduction polynomial x^N + POLY.
  function automatic int redPoly(int w);
    case (w)
      5:       return 'h05;   // x^5+x^2+1
      8:       return 'h1B;   // x^8+x^4+x^3+x+1
      default: return 'h03;   // x^N+x+1 (irreducible for N = 2,3,4,6,7)
    endcase
  endfunction

  localparam logic [N-1:0] POLY = N'(redPoly(N));

  logic [N-1:0] acc;
  logic [N-1:0] sh;

  // Shift-and-add with reduction folded into each doubling of A.
  always_comb begin
    acc = '0;
    sh  = AxDI;
    for (int k = 0; k < N; k++) begin
      if (BxDI[k]) acc = acc ^ sh;
      sh = {sh[N-2:0], 1'b0} ^ (sh[N-1] ? POLY : '0);
    end
    QxDO = acc;
  end
endmodule

module dom_shared_mul_gf2n_multi #(
  parameter int N         = 4,
  parameter int SHARES    = 2,
  parameter int NCH       = 2,
  parameter int PIPELINED = 1
) (
  input  logic                                          ClkxCI,
  input  logic                                          RstxBI,
  input  logic                                          InValidxSI,
  input  logic [NCH*SHARES*N-1:0]                       _XxDI,
  input  logic [SHARES*N-1:0]                           _YxDI,
  input  logic [NCH*(SHARES*(SHARES-1)/2)*N-1:0]        _ZxDI,
  output logic [NCH*SHARES*N-1:0]                       _QxDO,
  output logic                                          OutValidxSO
);
  localparam int NPAIR = SHARES * (SHARES - 1) / 2;

  // Lexicographic index of pair (a,b), a<b.
  function automatic int pairIdx(int a, int b);
    return a * SHARES - (a * (a + 1)) / 2 + (b - a - 1);
  endfunction

  logic [NCH*SHARES*N-1:0]        xS;
  logic [SHARES*N-1:0]            yS;
  logic                           vS;
  logic [NCH*SHARES*SHARES*N-1:0] termFlat;

  generate
    if (PIPELINED != 0) begin : gStage1
      logic [NCH*SHARES*N-1:0] xReg;
      logic [SHARES*N-1:0]     yReg;
      logic                    vReg;

      always_ff @(posedge ClkxCI or negedge RstxBI) begin
        if (!RstxBI) begin
          xReg <= '0;
          yReg <= '0;
          vReg <= 1'b0;
        end else begin
          vReg <= InValidxSI;
          if (InValidxSI) begin
            xReg <= _XxDI;
            yReg <= _YxDI;
          end
`ifdef DOM_MUL_CLEAR_ON_IDLE_EN
          else begin
            xReg <= '0;
            yReg <= '0;
          end
`endif
        end
      end

      assign xS = xReg;
      assign yS = yReg;
      assign vS = vReg;
    end else begin : gNoStage1
      assign xS = _XxDI;
      assign yS = _YxDI;
      assign vS = InValidxSI;
    end
  endgenerate

  // One register per (channel, share i, share j) domain term.
  genvar c, i, j;
  generate
    for (c = 0; c < NCH; c++) begin : gCh
      for (i = 0; i < SHARES; i++) begin : gI
        for (j = 0; j < SHARES; j++) begin : gJ
          logic [N-1:0] prod;
          logic [N-1:0] masked;
          logic [N-1:0] termQ;

          gf2_mul #(.N(N)) uMul (
            .AxDI(xS[(c*SHARES+i)*N +: N]),
            .BxDI(yS[j*N +: N]),
            .QxDO(prod)
          );

          if (i == j) begin : gInner
            assign masked = prod;
          end else begin : gCross
            // (i,j) and (j,i) share the same Z so the masks cancel on recombination.
            localparam int P = pairIdx((i < j) ? i : j, (i < j) ? j : i);
            assign masked = prod ^ _ZxDI[(c*NPAIR+P)*N +: N];
          end

          always_ff @(posedge ClkxCI or negedge RstxBI) begin
            if (!RstxBI) termQ <= '0;
            else if (vS) termQ <= masked;
`ifdef DOM_MUL_CLEAR_ON_IDLE_EN
            else         termQ <= '0;
`endif
          end

          assign termFlat[((c*SHARES+i)*SHARES+j)*N +: N] = termQ;
        end
      end
    end
  endgenerate

  always_ff @(posedge ClkxCI or negedge RstxBI) begin
    if (!RstxBI) OutValidxSO <= 1'b0;
    else         OutValidxSO <= vS;
  end

  // Output shares combine registered terms of the same share index only.
  always_comb begin
    _QxDO = '0;
    for (int cc = 0; cc < NCH; cc++)
      for (int ii = 0; ii < SHARES; ii++)
        for (int jj = 0; jj < SHARES; jj++)
          _QxDO[(cc*SHARES+ii)*N +: N] = _QxDO[(cc*SHARES+ii)*N +: N]
                                        ^ termFlat[((cc*SHARES+ii)*SHARES+jj)*N +: N];
  end
endmodule

// File: tb/tb_dom_shared_mul_gf2n_multi.sv
// tb/tb_dom_shared_mul_gf2n_multi.sv - self-checking bench for dom_shared_mul_gf2n_multi (two configurations)

module tb_dom_shared_mul_gf2n_multi;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  // Config A: N=4, S=2, NCH=2, PIPELINED=0
  logic        in0Valid;
  logic [15:0] x0;
  logic [7:0]  y0;
  logic [7:0]  z0;
  logic [15:0] q0;
  logic        out0Valid;

  // Config B: N=8, S=3, NCH=3, PIPELINED=1
  logic        in1Valid;
  logic [71:0] x1;
  logic [23:0] y1;
  logic [71:0] z1;
  logic [71:0] q1;
  logic        out1Valid;

  logic [127:0] lastQ0;

  always #5 clk = ~clk;

  dom_shared_mul_gf2n_multi #(.N(4), .SHARES(2), .NCH(2), .PIPELINED(0)) dut0 (
    .ClkxCI(clk), .RstxBI(rst_n), .InValidxSI(in0Valid),
    ._XxDI(x0), ._YxDI(y0), ._ZxDI(z0), ._QxDO(q0), .OutValidxSO(out0Valid)
  );

  dom_shared_mul_gf2n_multi #(.N(8), .SHARES(3), .NCH(3), .PIPELINED(1)) dut1 (
    .ClkxCI(clk), .RstxBI(rst_n), .InValidxSI(in1Valid),
    ._XxDI(x1), ._YxDI(y1), ._ZxDI(z1), ._QxDO(q1), .OutValidxSO(out1Valid)
  );

  // ---------------- reference model ----------------
  function automatic int gfmul(int a, int b, int n);
    int prod = 0;
    int poly = (n == 8) ? 'h11B : 'h13;
    for (int k = 0; k < n; k++)
      if (((b >> k) & 1) != 0) prod = prod ^ (a << k);
    for (int k = 2*n-2; k >= n; k--)
      if (((prod >> k) & 1) != 0) prod = prod ^ (poly << (k - n));
    return prod;
  endfunction

  function automatic int field(logic [127:0] v, int idx, int n);
    logic [127:0] t = v >> (idx * n);
    return int'(t[31:0]) & ((1 << n) - 1);
  endfunction

  function automatic int zOf(logic [127:0] z, int n, int s, int c, int a, int b);
    int lo = (a < b) ? a : b;
    int hi = (a < b) ? b : a;
    int np = s * (s - 1) / 2;
    int p = 0;
    int found = 0;
    for (int u = 0; u < s; u++)
      for (int v = u + 1; v < s; v++) begin
        if (u == lo && v == hi) found = p;
        p++;
      end
    return field(z, c * np + found, n);
  endfunction

  function automatic logic [127:0] mdlQ(int n, int s, int nch, logic [127:0] x, logic [127:0] y, logic [127:0] z);
    logic [127:0] q = '0;
    for (int c = 0; c < nch; c++)
      for (int i = 0; i < s; i++) begin
        int acc = 0;
        for (int j = 0; j < s; j++) begin
          int t = gfmul(field(x, c*s+i, n), field(y, j, n), n);
          if (j != i) t = t ^ zOf(z, n, s, c, i, j);
          acc = acc ^ t;
        end
        q = q | (128'(acc) << ((c*s+i)*n));
      end
    return q;
  endfunction

  function automatic int recomb(logic [127:0] v, int n, int s, int c);
    int r = 0;
    for (int i = 0; i < s; i++) r = r ^ field(v, c*s+i, n);
    return r;
  endfunction

  function automatic logic [127:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset;
    rst_n = 1'b0;
    in0Valid = 1'b0; x0 = '0; y0 = '0; z0 = '0;
    in1Valid = 1'b0; x1 = '0; y1 = '0; z1 = '0;
    repeat (2) @(negedge clk);
    checks++; if (out0Valid !== 1'b0) begin errors++; $display("FAIL reset_valid0 got %b exp 0", out0Valid); end
    checks++; if (q0 !== 16'h0) begin errors++; $display("FAIL reset_q0 got %h exp 0", q0); end
    checks++; if (out1Valid !== 1'b0) begin errors++; $display("FAIL reset_valid1 got %b exp 0", out1Valid); end
    checks++; if (q1 !== 72'h0) begin errors++; $display("FAIL reset_q1 got %h exp 0", q1); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (out0Valid !== 1'b0 || out1Valid !== 1'b0) begin
      errors++; $display("FAIL reset_release_valid got %b%b exp 00", out0Valid, out1Valid);
    end
  endtask

  task automatic test_basic;
    logic [127:0] exp;
    logic [127:0] tmp;
    @(negedge clk);
    tmp = rnd();
    x0 = {tmp[7:0], 8'h03};
    y0 = 8'h05;
    z0 = {tmp[11:8], 4'hA};
    in0Valid = 1'b1;
    exp = mdlQ(4, 2, 2, 128'(x0), 128'(y0), 128'(z0));
    @(negedge clk);
    in0Valid = 1'b0;
    checks++; if (out0Valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b exp 1", out0Valid); end
    checks++; if (q0[7:0] !== 8'hA5) begin errors++; $display("FAIL basic_ch0_shares got %h exp a5", q0[7:0]); end
    checks++; if ((q0[3:0] ^ q0[7:4]) !== 4'hF) begin
      errors++; $display("FAIL basic_recomb got %h exp f", q0[3:0] ^ q0[7:4]);
    end
    checks++; if (128'(q0) !== exp) begin errors++; $display("FAIL basic_model got %h exp %h", q0, exp); end
    x0 = rnd()[15:0]; y0 = $urandom; z0 = $urandom;
    @(negedge clk);
`ifdef DOM_MUL_CLEAR_ON_IDLE_EN
    exp = '0;
`endif
    checks++; if (out0Valid !== 1'b0) begin errors++; $display("FAIL basic_idle_valid got %b exp 0", out0Valid); end
    checks++; if (128'(q0) !== exp) begin errors++; $display("FAIL basic_idle_q got %h exp %h", q0, exp); end
    lastQ0 = exp;
  endtask

  task automatic test_zero_operand;
    logic [127:0] exp;
    @(negedge clk);
    x0 = {8'($urandom), 8'h77};
    y0 = $urandom;
    z0 = {4'($urandom), 4'h6};
    in0Valid = 1'b1;
    exp = mdlQ(4, 2, 2, 128'(x0), 128'(y0), 128'(z0));
    @(negedge clk);
    in0Valid = 1'b0;
    checks++; if (q0[3:0] !== q0[7:4]) begin errors++; $display("FAIL zero_shares_equal got %h %h", q0[3:0], q0[7:4]); end
    checks++; if ((q0[3:0] ^ q0[7:4]) !== 4'h0) begin
      errors++; $display("FAIL zero_recomb got %h exp 0", q0[3:0] ^ q0[7:4]);
    end
    checks++; if (128'(q0) !== exp) begin errors++; $display("FAIL zero_model got %h exp %h", q0, exp); end
    lastQ0 = exp;
  endtask

  task automatic test_random_gaps;
    logic [127:0] exp;
    logic         vPrev = 1'b0;
    logic [127:0] expPrev = '0;
    for (int n = 0; n <= 30; n++) begin
      @(negedge clk);
      if (n > 0) begin
        if (vPrev) exp = expPrev;
        else begin
`ifdef DOM_MUL_CLEAR_ON_IDLE_EN
          exp = '0;
`else
          exp = lastQ0;
`endif
        end
        checks++; if (out0Valid !== vPrev) begin errors++; $display("FAIL rand_valid[%0d] got %b exp %b", n, out0Valid, vPrev); end
        checks++; if (128'(q0) !== exp) begin errors++; $display("FAIL rand_q[%0d] got %h exp %h", n, q0, exp); end
        lastQ0 = exp;
      end
      in0Valid = (n < 30) ? 1'($urandom_range(0, 1)) : 1'b0;
      x0 = $urandom; y0 = $urandom; z0 = $urandom;
      vPrev = in0Valid;
      expPrev = mdlQ(4, 2, 2, 128'(x0), 128'(y0), 128'(z0));
    end
  endtask

  task automatic test_back_to_back;
    logic [71:0] sx[100];
    logic [23:0] sy[100];
    logic [71:0] sz[100];
    logic [127:0] tmp;
    logic [127:0] exp;
    for (int k = 0; k < 100; k++) begin
      tmp = rnd(); sx[k] = tmp[71:0];
      tmp = rnd(); sy[k] = tmp[23:0];
      tmp = rnd(); sz[k] = tmp[71:0];
    end
    for (int n = 0; n <= 103; n++) begin
      @(negedge clk);
      if (n >= 2 && n <= 101) begin
        exp = mdlQ(8, 3, 3, 128'(sx[n-2]), 128'(sy[n-2]), 128'(sz[n-2]));
        checks++; if (out1Valid !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d] got %b exp 1", n-2, out1Valid); end
        checks++; if (128'(q1) !== exp) begin errors++; $display("FAIL b2b_q[%0d] got %h exp %h", n-2, q1, exp); end
        for (int c = 0; c < 3; c++) begin
          checks++;
          if (recomb(128'(q1), 8, 3, c) != gfmul(recomb(128'(sx[n-2]), 8, 3, c), recomb(128'(sy[n-2]), 8, 3, 0), 8)) begin
            errors++; $display("FAIL b2b_recomb[%0d] ch%0d got %h", n-2, c, recomb(128'(q1), 8, 3, c));
          end
        end
      end else if (n >= 102) begin
        checks++; if (out1Valid !== 1'b0) begin errors++; $display("FAIL b2b_tail_valid[%0d] got %b exp 0", n, out1Valid); end
      end
      in1Valid = (n < 100);
      if (n < 100) begin x1 = sx[n]; y1 = sy[n]; end
      if (n >= 1 && n <= 100) z1 = sz[n-1];
      else begin tmp = rnd(); z1 = tmp[71:0]; end
    end
  endtask

  task automatic test_gap;
    logic         pat[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [127:0] gx[7];
    logic [127:0] gy[7];
    logic [127:0] gz[7];
    logic [127:0] exp = '0;
    logic         expV;
    for (int k = 0; k < 7; k++) begin gx[k] = rnd(); gy[k] = rnd(); gz[k] = rnd(); end
    for (int n = 0; n <= 6; n++) begin
      @(negedge clk);
      expV = (n >= 2) ? pat[n-2] : 1'b0;
      checks++; if (out1Valid !== expV) begin errors++; $display("FAIL gap_valid[%0d] got %b exp %b", n, out1Valid, expV); end
      if (n >= 2) begin
        if (expV) exp = mdlQ(8, 3, 3, gx[n-2] & {56'h0, {72{1'b1}}}, gy[n-2] & 128'hFFFFFF, gz[n-2] & {56'h0, {72{1'b1}}});
`ifdef DOM_MUL_CLEAR_ON_IDLE_EN
        else exp = '0;
`endif
        checks++; if (128'(q1) !== exp) begin errors++; $display("FAIL gap_q[%0d] got %h exp %h", n, q1, exp); end
      end
      in1Valid = pat[n];
      x1 = gx[n][71:0];
      y1 = gy[n][23:0];
      z1 = (n >= 1) ? gz[n-1][71:0] : 72'h0;
    end
  endtask

  task automatic test_reset_midop;
    logic [127:0] tmp;
    logic [127:0] exp;
    @(negedge clk);
    tmp = rnd(); x1 = tmp[71:0];
    tmp = rnd(); y1 = tmp[23:0];
    in1Valid = 1'b1;
    @(negedge clk);
    in1Valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++; if (out1Valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b exp 0", out1Valid); end
    checks++; if (q1 !== 72'h0) begin errors++; $display("FAIL midrst_q1 got %h exp 0", q1); end
    checks++; if (q0 !== 16'h0) begin errors++; $display("FAIL midrst_q0 got %h exp 0", q0); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      checks++; if (out1Valid !== 1'b0) begin errors++; $display("FAIL midrst_nopulse[%0d] got %b exp 0", n, out1Valid); end
    end
    // First op after release: no warm-up.
    tmp = rnd(); x1 = tmp[71:0];
    tmp = rnd(); y1 = tmp[23:0];
    in1Valid = 1'b1;
    @(negedge clk);
    in1Valid = 1'b0;
    tmp = rnd(); z1 = tmp[71:0];
    exp = mdlQ(8, 3, 3, 128'(x1), 128'(y1), 128'(z1));
    @(negedge clk);
    checks++; if (out1Valid !== 1'b1) begin errors++; $display("FAIL postrst_valid got %b exp 1", out1Valid); end
    checks++; if (128'(q1) !== exp) begin errors++; $display("FAIL postrst_q got %h exp %h", q1, exp); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    lastQ0 = '0;
    test_reset();
    test_basic();
    test_zero_operand();
    test_random_gaps();
    test_back_to_back();
    test_gap();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
